// File: rtl/audio_clk_gen.sv
// ---------------------------------------------------------------------------
// audio_clk_gen
//
// Generates a codec clock set from one system clock: mclk (clk / MCLK_DIV),
// bclk (mclk / BCLK_RATIO) and lrclk (bclk / FRAME_BITS). A frame_start pulse
// marks each lrclk 1->0 transition. in_en rises once SETTLE_FRAMES frames
// have completed.
//
// A stop request is deferred to the next frame boundary. All three clocks
// fall together there, so stopping never leaves a runt pulse.
//
// Optional feature: define AUDIO_CLK_STROBE_EN to add the bclk_rise and
// bclk_fall single-cycle strobes.
// ---------------------------------------------------------------------------
module audio_clk_gen #(
    parameter int MCLK_DIV      = 10,   // clk cycles per mclk period, even, >= 2
    parameter int BCLK_RATIO    = 4,    // mclk periods per bclk period, >= 1
    parameter int FRAME_BITS    = 384,  // bclk periods per lrclk frame, even, >= 2
    parameter int SETTLE_FRAMES = 8000  // completed frames before in_en, 1..65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mclk,
    output logic bclk,
    output logic lrclk,
    output logic frame_start,
    output logic in_en,
    output logic running
`ifdef AUDIO_CLK_STROBE_EN
    ,
    output logic bclk_rise,
    output logic bclk_fall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    // Half periods measured in clk cycles (mclk, bclk) and in bclk periods (lrclk).
    localparam int M_HALF = MCLK_DIV / 2;
    localparam int B_HALF = BCLK_RATIO * M_HALF;
    localparam int L_HALF = FRAME_BITS / 2;

    localparam int MW = (M_HALF > 1) ? $clog2(M_HALF) : 1;
    localparam int BW = (B_HALF > 1) ? $clog2(B_HALF) : 1;
    localparam int LW = (L_HALF > 1) ? $clog2(L_HALF) : 1;

    localparam logic [MW-1:0] M_LAST     = MW'(M_HALF - 1);
    localparam logic [BW-1:0] B_LAST     = BW'(B_HALF - 1);
    localparam logic [LW-1:0] L_LAST     = LW'(L_HALF - 1);
    localparam logic [15:0]   SETTLE_MAX = 16'(SETTLE_FRAMES);

    state_e          state_q,   state_d;
    logic [MW-1:0]   mcnt_q,    mcnt_d;
    logic [BW-1:0]   bcnt_q,    bcnt_d;
    logic [LW-1:0]   bitcnt_q,  bitcnt_d;
    logic            mclk_q,    mclk_d;
    logic            bclk_q,    bclk_d;
    logic            lrclk_q,   lrclk_d;
    logic            fs_q,      fs_d;
    logic [15:0]     settle_q,  settle_d;
    logic            in_en_q,   in_en_d;
    logic            running_q, running_d;
`ifdef AUDIO_CLK_STROBE_EN
    logic            rise_q,    rise_d;
    logic            fall_q,    fall_d;
`endif

    // Timing events derived from the current counter values.
    logic active;
    logic mclk_tick;
    logic bclk_tick;
    logic bclk_fall_evt;
    logic lr_tick;
    logic boundary;

    assign active        = (state_q != ST_IDLE);
    assign mclk_tick     = active && (mcnt_q == M_LAST);
    assign bclk_tick     = active && (bcnt_q == B_LAST);
    assign bclk_fall_evt = bclk_tick && bclk_q;
    assign lr_tick       = bclk_fall_evt && (bitcnt_q == L_LAST);
    assign boundary      = lr_tick && lrclk_q;

    // Next-state logic: FSM, clock dividers, frame pulse and settle tracking.
    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        mcnt_d    = '0;
        bcnt_d    = '0;
        bitcnt_d  = '0;
        mclk_d    = 1'b0;
        bclk_d    = 1'b0;
        lrclk_d   = 1'b0;
        fs_d      = 1'b0;
        settle_d  = '0;
        in_en_d   = 1'b0;
`ifdef AUDIO_CLK_STROBE_EN
        rise_d    = 1'b0;
        fall_d    = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE:     if (en) state_d = ST_RUN;
            ST_RUN:      if (!en) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (boundary)  state_d = ST_IDLE;
                else if (en)   state_d = ST_RUN;
            end
            default:     state_d = ST_IDLE;
        endcase

        running_d = (state_d != ST_IDLE);

        // Counters stay at zero while idle and restart from zero on RUN entry.
        // The stop boundary lands on a common falling edge, so forcing the
        // clocks low there coincides with their natural transition.
        if (active && running_d) begin
            mcnt_d   = mclk_tick ? '0 : mcnt_q + 1'b1;
            bcnt_d   = bclk_tick ? '0 : bcnt_q + 1'b1;
            mclk_d   = mclk_q ^ mclk_tick;
            bclk_d   = bclk_q ^ bclk_tick;
            bitcnt_d = bitcnt_q;
            if (bclk_fall_evt) begin
                bitcnt_d = (bitcnt_q == L_LAST) ? '0 : bitcnt_q + 1'b1;
            end
            lrclk_d  = lrclk_q ^ lr_tick;
            fs_d     = boundary;
`ifdef AUDIO_CLK_STROBE_EN
            rise_d   = ~bclk_q & bclk_d;
            fall_d   = bclk_q & ~bclk_d;
`endif
        end

        // Settle progress survives RUN<->STOPPING and clears only when idle.
        if (running_d) begin
            settle_d = settle_q;
            if (boundary && (settle_q < SETTLE_MAX)) begin
                settle_d = settle_q + 16'd1;
            end
            in_en_d = in_en_q | (settle_q == SETTLE_MAX);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // the values from before this edge regardless of statement order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mcnt_q    <= '0;
            bcnt_q    <= '0;
            bitcnt_q  <= '0;
            mclk_q    <= 1'b0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            fs_q      <= 1'b0;
            settle_q  <= '0;
            in_en_q   <= 1'b0;
            running_q <= 1'b0;
`ifdef AUDIO_CLK_STROBE_EN
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcnt_q    <= mcnt_d;
            bcnt_q    <= bcnt_d;
            bitcnt_q  <= bitcnt_d;
            mclk_q    <= mclk_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            fs_q      <= fs_d;
            settle_q  <= settle_d;
            in_en_q   <= in_en_d;
            running_q <= running_d;
`ifdef AUDIO_CLK_STROBE_EN
            rise_q    <= rise_d;
            fall_q    <= fall_d;
`endif
        end
    end

    assign mclk        = mclk_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign frame_start = fs_q;
    assign in_en       = in_en_q;
    assign running     = running_q;
`ifdef AUDIO_CLK_STROBE_EN
    assign bclk_rise   = rise_q;
    assign bclk_fall   = fall_q;
`endif

endmodule

// File: doc/audio_clk_gen.md
AUDIO_CLK_GEN -- requirements
Module: audio_clk_gen

Interface
REQ-001 Parameter MCLK_DIV, default 10: clk cycles per mclk period; even, >=2.
REQ-002 Parameter BCLK_RATIO, default 4: mclk periods per bclk period; >=1.
REQ-003 Parameter FRAME_BITS, default 384: bclk periods per lrclk frame; even, >=2.
REQ-004 Parameter SETTLE_FRAMES, default 8000: completed frames before in_en asserts; 1..65535.
REQ-005 clk  input  1  single system clock (125 MHz nominal); all logic on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 en  input  1  run request; level-sensitive.
REQ-008 mclk  output  1  codec master clock, registered.
REQ-009 bclk  output  1  serial bit clock, registered.
REQ-010 lrclk  output  1  frame clock; low = left slot, high = right slot; registered.
REQ-011 frame_start  output  1  one-clk pulse marking a frame boundary.
REQ-012 in_en  output  1  capture-enable flag, asserted once clocks have settled.
REQ-013 running  output  1  high in RUN or STOPPING.

Function
REQ-014 FSM states IDLE, RUN, STOPPING; IDLE->RUN when en=1; RUN->STOPPING when en=0; STOPPING->RUN when en=1; STOPPING->IDLE at the next frame boundary.
REQ-015 In IDLE: all internal counters 0; mclk, bclk, lrclk, frame_start = 0.
REQ-016 On IDLE->RUN, counters start from 0 in the first RUN cycle; the first mclk rise occurs MCLK_DIV/2 cycles after RUN entry.
REQ-017 mclk toggles every MCLK_DIV/2 clk cycles; bclk toggles every BCLK_RATIO*MCLK_DIV/2 cycles; both counters restart together, so every bclk edge coincides with an mclk edge.
REQ-018 lrclk toggles only in a cycle where bclk falls, every FRAME_BITS/2 bclk periods; with defaults, lrclk period = 15360 clk.
REQ-019 Frame boundary = lrclk 1->0 transition; frame_start = 1 in exactly that cycle, and in no other cycle.
REQ-020 No frame_start on IDLE->RUN; the first frame after start produces no pulse until its own completion.
REQ-021 Settle counter is 16 bits, increments on each frame_start, and saturates at SETTLE_FRAMES; in_en = 1 from the cycle after the count reaches SETTLE_FRAMES, sticky.
REQ-022 in_en and settle counter clear on entry to IDLE; they are retained across RUN<->STOPPING.
REQ-023 STOPPING: clocks continue unchanged until the frame boundary. In that cycle, state goes to IDLE, all clocks are driven 0, and frame_start is suppressed.
REQ-024 Since mclk, bclk and lrclk all fall at the frame boundary, stop produces no runt pulse on any clock.
REQ-025 en toggling within STOPPING before the boundary causes no clock discontinuity.
REQ-026 running is registered and equals (state != IDLE).

Reset
REQ-027 rst_n=0 at a clk edge: state=IDLE; all counters 0; mclk, bclk, lrclk, frame_start, in_en, running = 0 from that edge, irrespective of state or en.
REQ-028 Reset dominates en in the same cycle; normal operation resumes on the first edge with rst_n=1.

Configuration
REQ-029 Macro AUDIO_CLK_STROBE_EN defined: add outputs bclk_rise and bclk_fall (1 bit each), each a one-clk pulse in the cycle bclk goes 0->1 / 1->0; both 0 in IDLE and reset.
REQ-030 Macro undefined: those ports and their logic are absent; all other behaviour is identical.

Verification
REQ-031 Defaults, en=1 after reset -> mclk period 10, bclk period 40, first bclk rise 20 cycles after RUN entry, lrclk first rise at 7680, first frame_start at cycle 15360.
REQ-032 SETTLE_FRAMES=3, en held -> in_en rises 1 cycle after the 3rd frame_start and stays high; counter holds at 3.
REQ-033 Defaults, en dropped 5000 cycles into a frame -> clocks continue to the boundary at 15360, then all 0, running=0, in_en=0, no frame_start.
REQ-034 en dropped then re-raised 100 cycles later (before boundary) -> no clock gap, frame_start at 15360, in_en and settle count retained.
REQ-035 rst_n=0 for 1 cycle mid-frame with in_en=1 -> all outputs 0 next edge; restart with en=1 reproduces REQ-031 timing.
REQ-036 AUDIO_CLK_STROBE_EN defined, defaults -> exactly 384 bclk_fall and 384 bclk_rise pulses per frame; one bclk_fall coincides with each frame_start.
